// File: rtl/mux_arb_8ch.sv
// mux_arb_8ch: 8-channel round-robin arbiter/mux; ports clk, rst_n, req[7:0], din[8*WIDTH], o_ready in; ack[7:0], o, o_valid, sel out; MUX_ARB_PRIO_EN gives ch0 fixed priority
module mux_arb_8ch #(
  parameter int WIDTH = 4,
  parameter int SWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           req,
  input  logic [8*WIDTH-1:0]   din,
  output logic [7:0]           ack,
  output logic [WIDTH-1:0]     o,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [SWIDTH-1:0]    sel
);
  typedef enum logic {IDLE, FULL} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, win, idx;
  logic [7:0] rq;
  logic found, load;
  assign load = rst_n && (state == IDLE || o_ready) && |req;
  assign o_valid = state == FULL;
  always_comb begin
`ifdef MUX_ARB_PRIO_EN
    rq = req & 8'hFE;
`else
    rq = req;
`endif
    win = 3'd0;
    found = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && rq[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
`ifdef MUX_ARB_PRIO_EN
    if (req[0]) win = 3'd0;
    ptr_n = load ? (req[0] ? ptr : win + 3'd1) : ptr;
`else
    ptr_n = load ? win + 3'd1 : ptr;
`endif
    state_n = load ? FULL : (o_ready ? IDLE : state);
    ack = load ? 8'd1 << win : 8'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 3'd0;
      o <= '0;
      sel <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      if (load) begin
        o <= din[int'(win)*WIDTH +: WIDTH];
        sel <= SWIDTH'(win);
      end
    end
  end
endmodule

// File: tb/tb_mux_arb_8ch.sv
// tb_mux_arb_8ch: scoreboard bench for mux_arb_8ch with directed vectors
module tb_mux_arb_8ch;
  typedef struct {logic [3:0] d; logic [2:0] s;} w_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [31:0] din = 32'hE6C4521A;
  logic o_ready = 1'b0;
  logic [7:0] ack;
  logic [3:0] o;
  logic o_valid;
  logic [2:0] sel;
  int n_checks = 0;
  int n_fail = 0;
  w_t wq[$];
  logic [7:0] ackq[$];
  mux_arb_8ch #(.WIDTH(4), .SWIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack),
    .o(o), .o_valid(o_valid), .o_ready(o_ready), .sel(sel)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] dv(int k);
    return din[k*4 +: 4];
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] rq, input logic rdy,
                      input logic [7:0] ea, input logic ld, input int es);
    w_t w;
    @(posedge clk);
    #1;
    rst_n = r;
    req = rq;
    o_ready = rdy;
    ackq.push_back(ea);
    if (ld) begin
      w.d = dv(es);
      w.s = 3'(es);
      wq.push_back(w);
    end
    if (!r) begin
      wq.delete();
      #1;
      chk("rst_o_valid", {31'd0, o_valid}, 0);
      chk("rst_o", {28'd0, o}, 0);
      chk("rst_sel", {29'd0, sel}, 0);
    end
  endtask
  always @(negedge clk) begin
    w_t w;
    if (ackq.size() != 0) chk("ack", {24'd0, ack}, {24'd0, ackq.pop_front()});
    if (o_valid) begin
      if (wq.size() == 0) chk("unexpected_word", {31'd0, o_valid}, 0);
      else begin
        w = o_ready ? wq.pop_front() : wq[0];
        chk("o", {28'd0, o}, {28'd0, w.d});
        chk("sel", {29'd0, sel}, {29'd0, w.s});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step(0, 8'hFF, 1, 8'h00, 0, 0);
    step(0, 8'hFF, 1, 8'h00, 0, 0);
`ifdef MUX_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) step(1, 8'h07, 1, 8'h01, 1, 0);
    step(1, 8'h06, 1, 8'h02, 1, 1);
    step(1, 8'h06, 1, 8'h04, 1, 2);
    step(1, 8'h06, 1, 8'h02, 1, 1);
    step(1, 8'h06, 1, 8'h04, 1, 2);
`else
    step(1, 8'h01, 1, 8'h01, 1, 0);
    for (int i = 1; i <= 9; i++) step(1, 8'hFF, 1, 8'(1 << (i % 8)), 1, i % 8);
    step(1, 8'h08, 1, 8'h08, 1, 3);
    for (int i = 0; i < 4; i++) step(1, 8'h80, 0, 8'h00, 0, 0);
    step(1, 8'h80, 1, 8'h80, 1, 7);
    step(1, 8'h00, 1, 8'h00, 0, 0);
    step(1, 8'h00, 1, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'h10, 1, 8'h10, 1, 4);
    step(1, 8'h00, 0, 8'h00, 0, 0);
    step(0, 8'h81, 0, 8'h00, 0, 0);
    step(1, 8'h81, 0, 8'h01, 1, 0);
    step(1, 8'h81, 1, 8'h80, 1, 7);
`endif
    step(1, 8'h00, 1, 8'h00, 0, 0);
    step(1, 8'h00, 1, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk("drained", wq.size(), 0);
    chk("idle_o_valid", {31'd0, o_valid}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
